// File: rtl/mem_responder.sv
// Backing-memory responder: services one word read or write at a time against an
// internal array and returns a single-cycle response after a fixed latency.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3,
    parameter int INDEX_BITS  = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_valid,
    input  logic        mem_req_we,
    input  logic [31:0] mem_req_addr,
    input  logic [31:0] mem_req_wdata,
    output logic [31:0] mem_resp_rdata,
    output logic        mem_resp_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;

    logic                    req_we;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [31:0]             req_wdata;

    logic [31:0]             mem [DEPTH_WORDS];

    logic [INDEX_BITS-1:0]   in_idx;
    logic                    accept;
    logic                    commit;
    logic                    commit_we;
    logic [INDEX_BITS-1:0]   commit_idx;
    logic [31:0]             commit_wdata;

    // Byte-offset bits and bits above the array index alias away.
    logic                    unused_addr;

    assign in_idx      = mem_req_addr[INDEX_BITS+1:2];
    assign unused_addr = ^{mem_req_addr[31:INDEX_BITS+2], mem_req_addr[1:0]};

    // Commit happens on the edge that enters RESP; with single-cycle latency that is
    // the acceptance edge itself, so the live request fields are used directly.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        accept       = 1'b0;
        commit       = 1'b0;
        commit_we    = req_we;
        commit_idx   = req_idx;
        commit_wdata = req_wdata;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt    = RESP;
                        commit       = 1'b1;
                        commit_we    = mem_req_we;
                        commit_idx   = in_idx;
                        commit_wdata = mem_req_wdata;
                    end else begin
                        cnt_nxt   = 4'(LATENCY - 1);
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            mem_resp_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit && !commit_we) begin
                mem_resp_rdata <= mem[commit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_we    <= mem_req_we;
            req_idx   <= in_idx;
            req_wdata <= mem_req_wdata;
        end
    end

    // Array is not reset, but a reset on the would-be commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && commit && commit_we) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign mem_resp_valid = (state == RESP);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=3, one with LATENCY=1.
module tb_mem_responder;

    logic        clk;
    int          total;
    int          bad;

    logic        rst_n3, v3, we3;
    logic [31:0] addr3, wd3, rd3;
    logic        rv3, busy3;

    logic        rst_n1, v1, we1;
    logic [31:0] addr1, wd1, rd1;
    logic        rv1, busy1;

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .mem_req_valid(v3), .mem_req_we(we3),
        .mem_req_addr(addr3), .mem_req_wdata(wd3), .mem_resp_rdata(rd3),
        .mem_resp_valid(rv3), .busy(busy3)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .mem_req_valid(v1), .mem_req_we(we1),
        .mem_req_addr(addr1), .mem_req_wdata(wd1), .mem_resp_rdata(rd1),
        .mem_resp_valid(rv1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request on the LATENCY=3 instance; lat = negedges after acceptance
    // at which the response was seen (-1 if never).
    task automatic issue3(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd);
        @(negedge clk);
        v3 = 1'b1; we3 = we; addr3 = a; wd3 = d;
        lat = -1; rd = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rv3 === 1'b1) begin
                lat = i; rd = rd3;
                break;
            end
        end
        v3 = 1'b0;
    endtask

    task automatic issue1(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd);
        @(negedge clk);
        v1 = 1'b1; we1 = we; addr1 = a; wd1 = d;
        lat = -1; rd = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rv1 === 1'b1) begin
                lat = i; rd = rd1;
                break;
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n3 = 1'b0; rst_n1 = 1'b0;
        v3 = 1'b0; we3 = 1'b0; addr3 = 32'h0; wd3 = 32'h0;
        v1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wd1 = 32'h0;
        repeat (2) @(negedge clk);
        total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b exp=0", rv3); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
        total++; if (rd3 !== 32'h0) begin bad++; $display("FAIL reset_rdata3 got=%h exp=0", rd3); end
        total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b exp=0", rv1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", rd1); end
        rst_n3 = 1'b1; rst_n1 = 1'b1;
    endtask

    task automatic test_latency3();
        int          lat;
        logic [31:0] rd;
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b1; addr3 = 32'h0000_0010; wd3 = 32'hDEAD_BEEF;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (rv3 !== (i == 3)) begin
                bad++; $display("FAIL lat3_valid step=%0d got=%b exp=%b", i, rv3, (i == 3));
            end
            total++;
            if (busy3 !== (i <= 3)) begin
                bad++; $display("FAIL lat3_busy step=%0d got=%b exp=%b", i, busy3, (i <= 3));
            end
            if (i == 3) v3 = 1'b0;
        end
        total++; if (rd3 !== 32'h0) begin bad++; $display("FAIL lat3_write_no_rdata got=%h exp=0", rd3); end
        issue3(1'b0, 32'h0000_0010, 32'h0, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL lat3_read_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lat3_read_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_latency1();
        int t1;
        int t2;
        @(negedge clk);
        v1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0004; wd1 = 32'h1234_5678;
        t1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rv1 === 1'b1) begin t1 = i; break; end
        end
        we1 = 1'b0;
        t2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rv1 === 1'b1) begin t2 = i; break; end
        end
        total++; if (rd1 !== 32'h1234_5678) begin bad++; $display("FAIL lat1_raw_data got=%h exp=12345678", rd1); end
        v1 = 1'b0;
        total++; if (t1 !== 1) begin bad++; $display("FAIL lat1_write_latency got=%0d exp=1", t1); end
        total++; if (t2 !== 2) begin bad++; $display("FAIL lat1_spacing got=%0d exp=2", t2); end
        @(negedge clk);
        total++; if (rv1 !== 1'b0) begin bad++; $display("FAIL lat1_single_pulse got=%b exp=0", rv1); end
    endtask

    task automatic test_alias();
        int          lat;
        logic [31:0] rd;
        issue3(1'b1, 32'h0000_1008, 32'hA5A5_A5A5, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL alias_write_latency got=%0d exp=3", lat); end
        issue3(1'b0, 32'h0000_0008, 32'h0, lat, rd);
        total++; if (rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL alias_read_08 got=%h exp=a5a5a5a5", rd); end
        issue3(1'b0, 32'h0000_000B, 32'h0, lat, rd);
        total++; if (rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL alias_read_0b got=%h exp=a5a5a5a5", rd); end
    endtask

    task automatic test_input_change();
        int          lat;
        logic [31:0] rd;
        issue3(1'b1, 32'h0000_0020, 32'h1111_1111, lat, rd);
        issue3(1'b1, 32'h0000_0024, 32'h2222_2222, lat, rd);
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b0; addr3 = 32'h0000_0020; wd3 = 32'h0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin addr3 = 32'h0000_0024; we3 = 1'b1; wd3 = 32'h3333_3333; end
            if (rv3 === 1'b1) begin lat = i; break; end
        end
        total++; if (rd3 !== 32'h1111_1111) begin bad++; $display("FAIL hold_inputs_data got=%h exp=11111111", rd3); end
        total++; if (lat !== 3) begin bad++; $display("FAIL hold_inputs_latency got=%0d exp=3", lat); end
        v3 = 1'b0;
        issue3(1'b0, 32'h0000_0024, 32'h0, lat, rd);
        total++; if (rd !== 32'h2222_2222) begin bad++; $display("FAIL hold_inputs_no_write got=%h exp=22222222", rd); end
    endtask

    // rst_step: negedge after acceptance at which reset is driven low (2 = the commit edge).
    task automatic test_reset_wait(input int rst_step, input logic [31:0] wdata);
        int          lat;
        logic [31:0] rd;
        issue3(1'b1, 32'h0000_0040, 32'h0, lat, rd);
        issue3(1'b0, 32'h0000_0020, 32'h0, lat, rd);
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b1; addr3 = 32'h0000_0040; wd3 = wdata;
        repeat (rst_step) @(negedge clk);
        rst_n3 = 1'b0; v3 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total++;
            if (rv3 !== 1'b0 || busy3 !== 1'b0 || rd3 !== 32'h0) begin
                bad++;
                $display("FAIL rst_wait_outputs step=%0d valid=%b busy=%b rdata=%h exp=0/0/0",
                         i, rv3, busy3, rd3);
            end
            if (i == 1) rst_n3 = 1'b1;
        end
        issue3(1'b0, 32'h0000_0040, 32'h0, lat, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_wait_no_write got=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] rd;
        logic [31:0] exp_data [4];
        int          t;
        int          j;
        exp_data[0] = 32'h0BAD_0100; exp_data[1] = 32'h0BAD_0104;
        exp_data[2] = 32'h0BAD_0108; exp_data[3] = 32'h0BAD_010C;
        for (int k = 0; k < 4; k++) issue3(1'b1, 32'h100 + 32'(4 * k), exp_data[k], lat, rd);
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b0; addr3 = 32'h100; wd3 = 32'h0;
        t = 0; j = 0;
        while (j < 4 && t < 40) begin
            @(negedge clk);
            t++;
            if (rv3 === 1'b1) begin
                total++;
                if (rd3 !== exp_data[j]) begin
                    bad++; $display("FAIL refill_data word=%0d got=%h exp=%h", j, rd3, exp_data[j]);
                end
                total++;
                if (t !== 3 + 4 * j) begin
                    bad++; $display("FAIL refill_timing word=%0d got=%0d exp=%0d", j, t, 3 + 4 * j);
                end
                j++;
                if (j < 4) addr3 = 32'h100 + 32'(4 * j);
                else v3 = 1'b0;
            end
        end
        v3 = 1'b0;
        total++; if (j !== 4) begin bad++; $display("FAIL refill_count got=%0d exp=4", j); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_latency3();
        test_latency1();
        test_alias();
        test_input_change();
        test_reset_wait(1, 32'hCAFE_0000);
        test_reset_wait(2, 32'hCAFE_0001);
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
